alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one ALU instance (ALU + ALUop-encoded control) between two requesters, e.g. the main execute path and a secondary unit such as a branch-target or CSR path.
- Arbitrates round-robin and registers the operands driven into the shared ALU.
- Captures the ALU result and returns it to the requester that won, using a valid/ready handshake on both the request and response sides.
- Sits between the requesters and the combinational ALU; it contains no arithmetic itself.

Parameters:
WIDTH, 32, operand/result width
OPW, 4, ALUop width (matches ALUop.vh encoding)
CNTW, 16, width of completed-operation counter

Ports:
Clock  in  1  system clock, all state on rising edge
Reset_n  in  1  synchronous active-low reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle
req0_A  in  WIDTH  port 0 operand A
req0_B  in  WIDTH  port 0 operand B
req0_ALUop  in  OPW  port 0 ALU operation
req1_valid  in  1  port 1 request valid
req1_ready  out  1  port 1 request accepted this cycle
req1_A  in  WIDTH  port 1 operand A
req1_B  in  WIDTH  port 1 operand B
req1_ALUop  in  OPW  port 1 ALU operation
resp0_valid  out  1  port 0 result valid
resp0_ready  in  1  port 0 consumer ready
resp0_data  out  WIDTH  port 0 result
resp1_valid  out  1  port 1 result valid
resp1_ready  in  1  port 1 consumer ready
resp1_data  out  WIDTH  port 1 result
alu_A  out  WIDTH  registered operand A to shared ALU
alu_B  out  WIDTH  registered operand B to shared ALU
alu_ALUop  out  OPW  registered ALUop to shared ALU
alu_Out  in  WIDTH  combinational result from shared ALU
busy  out  1  high when state != IDLE
ops_done  out  CNTW  count of completed response handshakes

Behaviour:

Reset and clocking:
- One clock (Clock). Reset is synchronous and active-low (Reset_n).
- Reset values: state=IDLE; alu_A, alu_B, alu_ALUop = 0; result register = 0; owner = 0; last_grant = 1 (so port 0 wins the first tie); ops_done = 0.
- Output values under reset: all ready/valid outputs 0, busy 0.
- Reset asserted mid-operation drops the in-flight transaction. No response is issued.

State machine:
- States are IDLE, EXEC and RESP.
- IDLE, grant selection:
  - Grant is combinational.
  - Only reqN_valid high: grant N.
  - Both high: grant the port != last_grant.
  - Neither high: no grant.
- IDLE, ready outputs: reqN_ready = (state==IDLE) && grant==N. At most one ready is high. Ready is never high outside IDLE.
- IDLE, accept on the edge where valid&&ready:
  - alu_A <= reqN_A, alu_B <= reqN_B, alu_ALUop <= reqN_ALUop.
  - owner <= N, last_grant <= N.
  - state -> EXEC.
- EXEC (exactly 1 cycle): result <= alu_Out; state -> RESP.
- RESP:
  - resp<owner>_valid = 1 and resp<owner>_data = result.
  - The other port's valid is 0 and its data = result (don't-care).
  - Hold until resp<owner>_ready = 1. On that edge: state -> IDLE and ops_done += 1.
  - ops_done wraps from 2^CNTW-1 to 0.

Hold and ordering rules:
- alu_A/B/ALUop hold their last values in all states; they change only on accept.
- respN_data holds stable while valid and not ready.
- Requesters must hold A/B/ALUop stable while valid && !ready. The block does not check this.
- No new request is accepted in the RESP cycle, even if ready. Minimum latency from accept to resp_valid is 2 cycles. Maximum throughput is 1 op per 3 cycles.
- resp_ready while resp_valid is low is ignored.
- last_grant updates only on accept. Continuous dual requests therefore alternate 0,1,0,1.

Test Plan:
- Reset, then req0 only (A=0x00000005, B=0x00000003, ALUop=`ALU_ADD`, resp0_ready=1): req0_ready pulses once; resp0_valid rises 2 cycles after accept with resp0_data=0x00000008; ops_done=1; resp1_valid stays 0.
- Both ports request continuously (port0 `ALU_SUB` 10-4, port1 `ALU_XOR` 0xF0F0F0F0^0x0F0F0F0F), both resp_ready=1: grants occur in order 0,1,0,1; results 0x00000006 and 0xFFFFFFFF on the matching ports; never both ready in the same cycle.
- Backpressure: resp1_ready=0 for 5 cycles after resp1_valid (`ALU_SRA` 0x80000000>>>4): resp1_valid and resp1_data=0xF8000000 are held; req0_ready stays 0 while req0_valid=1; port 0 is accepted the cycle after resp1_ready goes high.
- Reset_n driven low during EXEC: next cycle busy=0, no resp_valid, alu_* = 0; a new req1 is then granted (last_grant reset to 1 makes port 0 win a tie, but only port 1 is requesting here).
- Counter wrap: preload via 65536 ADD transactions (or force) → ops_done returns to 0x0000 on the 65536th handshake.
- Random regression: 500 ops with random valid/ready on both ports and random ALUop; a scoreboard compares each response against a reference ALU model and checks per-port ordering.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered into the ALU, the result is captured and returned to the winner.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4,
  parameter int CNTW  = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic [OPW-1:0]   req0_ALUop,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  input  logic [OPW-1:0]   req1_ALUop,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_data,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_data,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [OPW-1:0]   alu_ALUop,
  input  logic [WIDTH-1:0] alu_Out,
  output logic             busy,
  output logic [CNTW-1:0]  ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [CNTW-1:0]  ops_done_q, ops_done_d;

  logic grant_valid;
  logic grant_port;
  logic in_idle;
  logic in_resp;
  logic owner_ready;

  // A tie goes to the port that did not win the previous accept.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_port  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_port = ~last_grant_q;
    end else if (req1_valid) begin
      grant_port = 1'b1;
    end
  end

  assign in_idle     = Reset_n && (state_q == IDLE);
  assign in_resp     = Reset_n && (state_q == RESP);
  assign owner_ready = owner_q ? resp1_ready : resp0_ready;

  assign req0_ready  = in_idle && grant_valid && !grant_port;
  assign req1_ready  = in_idle && grant_valid && grant_port;
  assign resp0_valid = in_resp && !owner_q;
  assign resp1_valid = in_resp && owner_q;
  assign resp0_data  = result_q;
  assign resp1_data  = result_q;
  assign alu_A       = alu_a_q;
  assign alu_B       = alu_b_q;
  assign alu_ALUop   = alu_op_q;
  assign busy        = Reset_n && (state_q != IDLE);
  assign ops_done    = ops_done_q;

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    result_d     = result_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    ops_done_d   = ops_done_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          alu_a_d      = grant_port ? req1_A : req0_A;
          alu_b_d      = grant_port ? req1_B : req0_B;
          alu_op_d     = grant_port ? req1_ALUop : req0_ALUop;
          owner_d      = grant_port;
          last_grant_d = grant_port;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_Out;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_ready) begin
          ops_done_d = ops_done_q + CNTW'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      result_q     <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      result_q     <= result_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      ops_done_q   <= ops_done_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a bench-side ALU drives alu_Out, and each
// accepted request pushes its reference result onto a per-port queue popped on response.
module tb_alu_share_arbiter;

  localparam int WIDTH = 32;
  localparam int OPW   = 4;
  localparam int CNTW  = 8;

  localparam logic [OPW-1:0] ALU_ADD  = 4'd0;
  localparam logic [OPW-1:0] ALU_SUB  = 4'd1;
  localparam logic [OPW-1:0] ALU_AND  = 4'd2;
  localparam logic [OPW-1:0] ALU_OR   = 4'd3;
  localparam logic [OPW-1:0] ALU_XOR  = 4'd4;
  localparam logic [OPW-1:0] ALU_SLL  = 4'd5;
  localparam logic [OPW-1:0] ALU_SRL  = 4'd6;
  localparam logic [OPW-1:0] ALU_SRA  = 4'd7;
  localparam logic [OPW-1:0] ALU_SLT  = 4'd8;
  localparam logic [OPW-1:0] ALU_SLTU = 4'd9;

  logic             Clock;
  logic             Reset_n;
  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_A, req0_B;
  logic [OPW-1:0]   req0_ALUop;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_A, req1_B;
  logic [OPW-1:0]   req1_ALUop;
  logic             resp0_valid, resp0_ready;
  logic [WIDTH-1:0] resp0_data;
  logic             resp1_valid, resp1_ready;
  logic [WIDTH-1:0] resp1_data;
  logic [WIDTH-1:0] alu_A, alu_B, alu_Out;
  logic [OPW-1:0]   alu_ALUop;
  logic             busy;
  logic [CNTW-1:0]  ops_done;

  int errors = 0;
  int checks = 0;
  int pops0  = 0;
  int pops1  = 0;
  logic [WIDTH-1:0] q0 [$];
  logic [WIDTH-1:0] q1 [$];
  int               grant_log [$];
  logic [CNTW-1:0]  exp_ops = '0;
  logic             hold0 = 1'b0;
  logic             hold1 = 1'b0;
  logic [WIDTH-1:0] hold_data0, hold_data1;

  function automatic logic [WIDTH-1:0] alu_model(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [OPW-1:0] op);
    logic [WIDTH-1:0] r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign alu_Out = alu_model(alu_A, alu_B, alu_ALUop);

  alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(CNTW)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
    .req0_ALUop(req0_ALUop),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
    .req1_ALUop(req1_ALUop),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop), .alu_Out(alu_Out),
    .busy(busy), .ops_done(ops_done)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Sees pre-edge values: records accepts, pops responses, tracks the counter and hold rules.
  always @(posedge Clock) begin
    if (!Reset_n) begin
      q0.delete();
      q1.delete();
      exp_ops = '0;
      hold0   = 1'b0;
      hold1   = 1'b0;
    end else begin
      checks++;
      if (req0_ready && req1_ready) begin
        errors++;
        $display("[TB] FAIL both_ready: got 1 expected 0");
      end
      checks++;
      if ((req0_ready || req1_ready) && busy) begin
        errors++;
        $display("[TB] FAIL ready_while_busy: got 1 expected 0");
      end
      checks++;
      if (ops_done !== exp_ops) begin
        errors++;
        $display("[TB] FAIL ops_done: got %0d expected %0d", ops_done, exp_ops);
      end
      if (hold0) begin
        checks++;
        if (resp0_valid !== 1'b1 || resp0_data !== hold_data0) begin
          errors++;
          $display("[TB] FAIL resp0_hold: got v=%b d=%h expected v=1 d=%h", resp0_valid, resp0_data, hold_data0);
        end
      end
      if (hold1) begin
        checks++;
        if (resp1_valid !== 1'b1 || resp1_data !== hold_data1) begin
          errors++;
          $display("[TB] FAIL resp1_hold: got v=%b d=%h expected v=1 d=%h", resp1_valid, resp1_data, hold_data1);
        end
      end
      hold0      = resp0_valid && !resp0_ready;
      hold1      = resp1_valid && !resp1_ready;
      hold_data0 = resp0_data;
      hold_data1 = resp1_data;
      if (req0_valid && req0_ready) begin
        q0.push_back(alu_model(req0_A, req0_B, req0_ALUop));
        grant_log.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        q1.push_back(alu_model(req1_A, req1_B, req1_ALUop));
        grant_log.push_back(1);
      end
      if (resp0_valid && resp0_ready) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("[TB] FAIL resp0_spurious: got data=%h expected no response", resp0_data);
        end else begin
          logic [WIDTH-1:0] e0;
          e0 = q0.pop_front();
          if (resp0_data !== e0) begin
            errors++;
            $display("[TB] FAIL resp0_data: got %h expected %h", resp0_data, e0);
          end
        end
        pops0++;
        exp_ops = exp_ops + CNTW'(1);
      end
      if (resp1_valid && resp1_ready) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("[TB] FAIL resp1_spurious: got data=%h expected no response", resp1_data);
        end else begin
          logic [WIDTH-1:0] e1;
          e1 = q1.pop_front();
          if (resp1_data !== e1) begin
            errors++;
            $display("[TB] FAIL resp1_data: got %h expected %h", resp1_data, e1);
          end
        end
        pops1++;
        exp_ops = exp_ops + CNTW'(1);
      end
    end
  end

  task automatic apply_reset();
    @(negedge Clock);
    Reset_n     = 1'b0;
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge Clock);
      #1;
      if (!busy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s_idle_timeout: got busy=1 expected busy=0", name);
    end
  endtask

  task automatic test_reset();
    @(negedge Clock);
    Reset_n    = 1'b0;
    req0_valid = 1'b1;
    req0_A     = 32'h1;
    req0_B     = 32'h1;
    req0_ALUop = ALU_ADD;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || resp0_valid !== 1'b0 ||
        resp1_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got r0=%b r1=%b v0=%b v1=%b busy=%b expected all 0",
               req0_ready, req1_ready, resp0_valid, resp1_valid, busy);
    end
    @(negedge Clock);
    #1;
    checks++;
    if (alu_A !== '0 || alu_B !== '0 || alu_ALUop !== '0 || ops_done !== '0) begin
      errors++;
      $display("[TB] FAIL reset_regs: got A=%h B=%h op=%h ops=%0d expected 0", alu_A, alu_B, alu_ALUop, ops_done);
    end
    req0_valid = 1'b0;
    Reset_n    = 1'b1;
    @(negedge Clock);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req1_A     = 32'h1;
    req1_B     = 32'h1;
    req1_ALUop = ALU_ADD;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_first_tie: got r0=%b r1=%b expected r0=1 r1=0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_single();
    int pulses = 0;
    apply_reset();
    req0_A      = 32'h5;
    req0_B      = 32'h3;
    req0_ALUop  = ALU_ADD;
    req0_valid  = 1'b1;
    resp0_ready = 1'b1;
    #1;
    if (req0_ready) pulses++;
    @(negedge Clock);
    req0_valid = 1'b0;
    #1;
    if (req0_ready) pulses++;
    checks++;
    if (busy !== 1'b1 || resp0_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_exec: got busy=%b v0=%b expected busy=1 v0=0", busy, resp0_valid);
    end
    @(negedge Clock);
    #1;
    checks++;
    if (resp0_valid !== 1'b1 || resp0_data !== 32'h8 || resp1_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_resp: got v0=%b d=%h v1=%b expected v0=1 d=00000008 v1=0",
               resp0_valid, resp0_data, resp1_valid);
    end
    @(negedge Clock);
    #1;
    checks++;
    if (ops_done !== 8'd1 || busy !== 1'b0 || resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_done: got ops=%0d busy=%b v0=%b v1=%b expected ops=1 busy=0 v0=0 v1=0",
               ops_done, busy, resp0_valid, resp1_valid);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("[TB] FAIL single_ready_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_both();
    int p0 = 0;
    int p1 = 0;
    apply_reset();
    grant_log.delete();
    p0 = pops0;
    p1 = pops1;
    req0_A      = 32'd10;
    req0_B      = 32'd4;
    req0_ALUop  = ALU_SUB;
    req1_A      = 32'hF0F0F0F0;
    req1_B      = 32'h0F0F0F0F;
    req1_ALUop  = ALU_XOR;
    req0_valid  = 1'b1;
    req1_valid  = 1'b1;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (resp0_valid) begin
        checks++;
        if (resp0_data !== 32'h6) begin
          errors++;
          $display("[TB] FAIL both_resp0: got %h expected 00000006", resp0_data);
        end
      end
      if (resp1_valid) begin
        checks++;
        if (resp1_data !== 32'hFFFFFFFF) begin
          errors++;
          $display("[TB] FAIL both_resp1: got %h expected ffffffff", resp1_data);
        end
      end
      @(negedge Clock);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle("both");
    checks++;
    if (grant_log.size() < 4) begin
      errors++;
      $display("[TB] FAIL both_grant_count: got %0d expected >=4", grant_log.size());
    end else if (grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 0 || grant_log[3] != 1) begin
      errors++;
      $display("[TB] FAIL both_grant_order: got %0d%0d%0d%0d expected 0101",
               grant_log[0], grant_log[1], grant_log[2], grant_log[3]);
    end
    checks++;
    if (pops0 - p0 < 2 || pops1 - p1 < 2) begin
      errors++;
      $display("[TB] FAIL both_completions: got p0=%0d p1=%0d expected >=2 each", pops0 - p0, pops1 - p1);
    end
  endtask

  task automatic test_backpressure();
    @(negedge Clock);
    req0_valid  = 1'b0;
    req1_A      = 32'h80000000;
    req1_B      = 32'd4;
    req1_ALUop  = ALU_SRA;
    req1_valid  = 1'b1;
    resp1_ready = 1'b0;
    resp0_ready = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_accept1: got %b expected 1", req1_ready);
    end
    @(negedge Clock);
    req1_valid = 1'b0;
    req0_A     = 32'd1;
    req0_B     = 32'd2;
    req0_ALUop = ALU_ADD;
    req0_valid = 1'b1;
    @(negedge Clock);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (resp1_valid !== 1'b1 || resp1_data !== 32'hF8000000 || req0_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold: got v1=%b d=%h r0=%b expected v1=1 d=f8000000 r0=0",
                 resp1_valid, resp1_data, req0_ready);
      end
      @(negedge Clock);
    end
    resp1_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || resp1_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release: got r0=%b v1=%b expected r0=0 v1=1", req0_ready, resp1_valid);
    end
    @(negedge Clock);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_next_grant: got r0=%b busy=%b expected r0=1 busy=0", req0_ready, busy);
    end
    @(negedge Clock);
    req0_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_port0_accepted: got busy=%b expected 1", busy);
    end
    wait_idle("bp");
  endtask

  task automatic test_reset_mid();
    int p0 = 0;
    int p1 = 0;
    @(negedge Clock);
    req0_A      = 32'd7;
    req0_B      = 32'd9;
    req0_ALUop  = ALU_ADD;
    req0_valid  = 1'b1;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_accept: got %b expected 1", req0_ready);
    end
    @(negedge Clock);
    req0_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_exec: got busy=%b expected 1", busy);
    end
    Reset_n = 1'b0;
    @(negedge Clock);
    #1;
    checks++;
    if (busy !== 1'b0 || resp0_valid !== 1'b0 || resp1_valid !== 1'b0 ||
        alu_A !== '0 || alu_B !== '0 || alu_ALUop !== '0 || ops_done !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_state: got busy=%b v0=%b v1=%b A=%h B=%h op=%h ops=%0d expected all 0",
               busy, resp0_valid, resp1_valid, alu_A, alu_B, alu_ALUop, ops_done);
    end
    p0 = pops0;
    p1 = pops1;
    Reset_n    = 1'b1;
    req1_A     = 32'h10;
    req1_B     = 32'h22;
    req1_ALUop = ALU_OR;
    req1_valid = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_regrant: got r0=%b r1=%b expected r0=0 r1=1", req0_ready, req1_ready);
    end
    @(negedge Clock);
    req1_valid = 1'b0;
    wait_idle("mid");
    checks++;
    if (pops0 != p0 || pops1 != p1 + 1) begin
      errors++;
      $display("[TB] FAIL mid_responses: got p0=%0d p1=%0d expected p0=0 p1=1", pops0 - p0, pops1 - p1);
    end
  endtask

  task automatic test_wrap();
    bit found = 1'b0;
    apply_reset();
    req0_A      = 32'd1;
    req0_B      = 32'd1;
    req0_ALUop  = ALU_ADD;
    req0_valid  = 1'b1;
    resp0_ready = 1'b1;
    for (int i = 0; i < 1500 && !found; i++) begin
      #1;
      if (ops_done == 8'hFF) found = 1'b1;
      else @(negedge Clock);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL wrap_reach_max: got %0d expected 255", ops_done);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge Clock);
      #1;
      if (resp0_valid) found = 1'b1;
    end
    req0_valid = 1'b0;
    checks++;
    if (!found || ops_done !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL wrap_pre: got valid=%b ops=%0d expected valid=1 ops=255", found, ops_done);
    end
    @(negedge Clock);
    #1;
    checks++;
    if (ops_done !== 8'h00) begin
      errors++;
      $display("[TB] FAIL wrap_zero: got %0d expected 0", ops_done);
    end
    wait_idle("wrap");
  endtask

  task automatic test_random();
    int  target = 0;
    int  cycles = 0;
    bit  acc0 = 1'b1;
    bit  acc1 = 1'b1;
    apply_reset();
    target = pops0 + pops1 + 500;
    while (pops0 + pops1 < target && cycles < 20000) begin
      if (!req0_valid || acc0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_A     = $urandom();
        req0_B     = $urandom();
        req0_ALUop = OPW'($urandom_range(0, 9));
      end
      if (!req1_valid || acc1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_A     = $urandom();
        req1_B     = $urandom();
        req1_ALUop = OPW'($urandom_range(0, 9));
      end
      resp0_ready = 1'($urandom_range(0, 1));
      resp1_ready = 1'($urandom_range(0, 1));
      #1;
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      cycles++;
      @(negedge Clock);
    end
    checks++;
    if (cycles >= 20000) begin
      errors++;
      $display("[TB] FAIL random_timeout: got %0d ops expected 500", 500 - (target - pops0 - pops1));
    end
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    wait_idle("random");
    @(negedge Clock);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("[TB] FAIL random_drain: got q0=%0d q1=%0d expected 0 0", q0.size(), q1.size());
    end
  endtask

  initial begin
    Reset_n     = 1'b0;
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    req0_A      = '0;
    req0_B      = '0;
    req0_ALUop  = '0;
    req1_A      = '0;
    req1_B      = '0;
    req1_ALUop  = '0;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    test_reset();
    test_single();
    test_both();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
